hcpu_mc: RTL and testbench

HCPU_MC -- requirements
Module: hcpu_mc

---
 rtl/hcpu_mc.sv | 149 ++++++++++++++
 tb/tb_hcpu_mc.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hcpu_mc.sv
// Multi-cycle Hack CPU: fetch, decode, optional M read, execute, optional M write.
// Instruction and data memories are reached through separate request/handshake ports.
module hcpu_mc #(
    parameter int WIDTH    = 16,
    parameter int PC_WIDTH = 15
) (
    input  logic                clock,
    input  logic                reset,
    output logic                instr_req,
    output logic [PC_WIDTH-1:0] instr_addr,
    input  logic                instr_valid,
    input  logic [WIDTH-1:0]    instr_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [WIDTH-1:0]    mem_addr,
    output logic [WIDTH-1:0]    mem_wdata,
    input  logic [WIDTH-1:0]    mem_rdata,
    input  logic                mem_ready,
    output logic [PC_WIDTH-1:0] pc,
    output logic                retired
);

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        MREAD,
        EXEC,
        MWRITE
    } state_t;

    state_t              state;
    logic [WIDTH-1:0]    ir;
    logic [WIDTH-1:0]    a_reg;
    logic [WIDTH-1:0]    d_reg;
    logic [WIDTH-1:0]    mreg;
    logic [WIDTH-1:0]    waddr;
    logic [WIDTH-1:0]    wdata;
    logic [PC_WIDTH-1:0] pc_q;
    logic                retired_q;

    logic                is_c;
    logic                c_a;
    logic [5:0]          c_comp;
    logic [2:0]          c_dest;
    logic [2:0]          c_jump;

    logic [WIDTH-1:0]    alu_x;
    logic [WIDTH-1:0]    alu_y;
    logic [WIDTH-1:0]    alu_r;
    logic                zr;
    logic                ng;
    logic                jump;

    assign is_c   = ir[WIDTH-1];
    assign c_a    = ir[12];
    assign c_comp = ir[11:6];
    assign c_dest = ir[5:3];
    assign c_jump = ir[2:0];

    // Hack ALU: x is always D, y is M when a=1 and A otherwise.
    always_comb begin
        alu_x = d_reg;
        alu_y = c_a ? mreg : a_reg;
        if (c_comp[5]) alu_x = '0;
        if (c_comp[4]) alu_x = ~alu_x;
        if (c_comp[3]) alu_y = '0;
        if (c_comp[2]) alu_y = ~alu_y;
        alu_r = c_comp[1] ? (alu_x + alu_y) : (alu_x & alu_y);
        if (c_comp[0]) alu_r = ~alu_r;
    end

    assign zr   = (alu_r == '0);
    assign ng   = alu_r[WIDTH-1];
    assign jump = (c_jump[2] & ng) | (c_jump[1] & zr) | (c_jump[0] & ~ng & ~zr);

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= FETCH;
            ir        <= '0;
            a_reg     <= '0;
            d_reg     <= '0;
            mreg      <= '0;
            waddr     <= '0;
            wdata     <= '0;
            pc_q      <= '0;
            retired_q <= 1'b0;
        end else begin
            retired_q <= 1'b0;
            case (state)
                FETCH: begin
                    if (instr_valid) begin
                        ir    <= instr_data;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    if (!is_c) begin
                        a_reg     <= {1'b0, ir[WIDTH-2:0]};
                        pc_q      <= pc_q + 1'b1;
                        retired_q <= 1'b1;
                        state     <= FETCH;
                    end else if (c_a) begin
                        state <= MREAD;
                    end else begin
                        state <= EXEC;
                    end
                end
                MREAD: begin
                    if (mem_ready) begin
                        mreg  <= mem_rdata;
                        state <= EXEC;
                    end
                end
                // The jump target and the write address both use A before this cycle's write.
                EXEC: begin
                    pc_q <= jump ? a_reg[PC_WIDTH-1:0] : pc_q + 1'b1;
                    if (c_dest[2]) a_reg <= alu_r;
                    if (c_dest[1]) d_reg <= alu_r;
                    if (c_dest[0]) begin
                        waddr <= a_reg;
                        wdata <= alu_r;
                        state <= MWRITE;
                    end else begin
                        retired_q <= 1'b1;
                        state     <= FETCH;
                    end
                end
                MWRITE: begin
                    if (mem_ready) begin
                        retired_q <= 1'b1;
                        state     <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // Requests are masked while reset is low so the bus goes quiet immediately.
    assign instr_req  = reset & (state == FETCH);
    assign instr_addr = pc_q;
    assign mem_req    = reset & ((state == MREAD) | (state == MWRITE));
    assign mem_we     = reset & (state == MWRITE);
    assign mem_addr   = (state == MWRITE) ? waddr : a_reg;
    assign mem_wdata  = wdata;
    assign pc         = pc_q;
    assign retired    = reset & retired_q;

endmodule

// File: tb/tb_hcpu_mc.sv
// Scoreboard bench for hcpu_mc: a 16-bit and a 32-bit instance share one stimulus driver,
// the unselected instance is held in reset.
module tb_hcpu_mc;

    logic        clock;
    logic        rst;
    logic        sel32;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    logic        reset16, reset32;
    logic        instr_req16, instr_req32;
    logic [14:0] instr_addr16, instr_addr32;
    logic        mem_req16, mem_req32;
    logic        mem_we16, mem_we32;
    logic [15:0] mem_addr16, mem_wdata16;
    logic [31:0] mem_addr32, mem_wdata32;
    logic [14:0] pc16, pc32;
    logic        retired16, retired32;

    logic        o_instr_req;
    logic [14:0] o_instr_addr;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic [14:0] o_pc;
    logic        o_retired;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } acc_t;

    acc_t        exp_q[$];
    logic [14:0] model_pc;
    int          checks;
    int          passes;

    assign reset16 = rst & ~sel32;
    assign reset32 = rst & sel32;

    hcpu_mc #(.WIDTH(16), .PC_WIDTH(15)) u_dut16 (
        .clock      (clock),
        .reset      (reset16),
        .instr_req  (instr_req16),
        .instr_addr (instr_addr16),
        .instr_valid(instr_valid),
        .instr_data (instr_data[15:0]),
        .mem_req    (mem_req16),
        .mem_we     (mem_we16),
        .mem_addr   (mem_addr16),
        .mem_wdata  (mem_wdata16),
        .mem_rdata  (mem_rdata[15:0]),
        .mem_ready  (mem_ready),
        .pc         (pc16),
        .retired    (retired16)
    );

    hcpu_mc #(.WIDTH(32), .PC_WIDTH(15)) u_dut32 (
        .clock      (clock),
        .reset      (reset32),
        .instr_req  (instr_req32),
        .instr_addr (instr_addr32),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .mem_req    (mem_req32),
        .mem_we     (mem_we32),
        .mem_addr   (mem_addr32),
        .mem_wdata  (mem_wdata32),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .pc         (pc32),
        .retired    (retired32)
    );

    assign o_instr_req  = sel32 ? instr_req32  : instr_req16;
    assign o_instr_addr = sel32 ? instr_addr32 : instr_addr16;
    assign o_mem_req    = sel32 ? mem_req32    : mem_req16;
    assign o_mem_we     = sel32 ? mem_we32     : mem_we16;
    assign o_mem_addr   = sel32 ? mem_addr32   : {16'h0000, mem_addr16};
    assign o_mem_wdata  = sel32 ? mem_wdata32  : {16'h0000, mem_wdata16};
    assign o_pc         = sel32 ? pc32         : pc16;
    assign o_retired    = sel32 ? retired32    : retired16;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
        end
    endtask

    task automatic expectRead(input logic [31:0] addr);
        acc_t e;
        e.we   = 1'b0;
        e.addr = addr;
        e.data = '0;
        exp_q.push_back(e);
    endtask

    task automatic expectWrite(input logic [31:0] addr, input logic [31:0] data);
        acc_t e;
        e.we   = 1'b1;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic applyReset(input logic use32);
        sel32       = use32;
        rst         = 1'b0;
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
            checkOutput("rst_instr_req", o_instr_req, 0);
            checkOutput("rst_mem_req", o_mem_req, 0);
            checkOutput("rst_retired", o_retired, 0);
        end
        @(negedge clock);
        rst = 1'b1;
        #1;
        checkOutput("post_rst_instr_req", o_instr_req, 1);
        checkOutput("post_rst_instr_addr", o_instr_addr, 0);
        checkOutput("post_rst_pc", o_pc, 0);
        checkOutput("post_rst_mem_req", o_mem_req, 0);
        model_pc = '0;
    endtask

    // Runs one instruction through fetch and memory handshakes, checking bus traffic
    // against the queued expectations and the latency/pc against the caller's model.
    task automatic applyStimulus(input logic [31:0] instr, input int fetch_wait, input int mem_wait,
                                 input logic [31:0] rdata, input int base_cycles,
                                 input logic [14:0] exp_pc);
        int   stall;
        int   mstall;
        int   cycles;
        logic done;
        stall  = fetch_wait;
        mstall = mem_wait;
        cycles = 0;
        done   = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            instr_valid = 1'b0;
            mem_ready   = 1'b0;
            checkOutput("req_exclusive", {31'b0, o_instr_req & o_mem_req}, 0);
            if (o_instr_req) begin
                checkOutput("fetch_addr", o_instr_addr, model_pc);
                if (stall > 0) begin
                    stall--;
                end else begin
                    instr_valid = 1'b1;
                    instr_data  = instr;
                end
            end
            if (o_mem_req) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_access", o_mem_req, 0);
                end else begin
                    checkOutput("mem_we", o_mem_we, exp_q[0].we);
                    checkOutput("mem_addr", o_mem_addr, exp_q[0].addr);
                    if (exp_q[0].we) checkOutput("mem_wdata", o_mem_wdata, exp_q[0].data);
                    if (mstall > 0) begin
                        mstall--;
                    end else begin
                        mem_ready = 1'b1;
                        mem_rdata = rdata;
                        void'(exp_q.pop_front());
                    end
                end
            end
            @(posedge clock);
            cycles++;
            #1;
            if (o_retired) done = 1'b1;
            else @(negedge clock);
        end
        checkOutput("retired", {31'b0, done}, 1);
        checkOutput("latency", cycles, base_cycles + fetch_wait + mem_wait);
        checkOutput("pc", o_pc, exp_pc);
        checkOutput("pending_access", exp_q.size(), 0);
        exp_q.delete();
        model_pc = exp_pc;
        if (done) @(negedge clock);
        instr_valid = 1'b0;
        mem_ready   = 1'b0;
        @(posedge clock);
        #1;
        checkOutput("retired_pulse", o_retired, 0);
        @(negedge clock);
    endtask

    initial begin
        checks      = 0;
        passes      = 0;
        rst         = 1'b0;
        sel32       = 1'b0;
        instr_valid = 1'b0;
        instr_data  = '0;
        mem_ready   = 1'b0;
        mem_rdata   = '0;
        model_pc    = '0;
        @(negedge clock);

        applyReset(1'b0);

        // Fetch stall, then D=A and a stalled M=D+1 write.
        applyStimulus(32'h0005, 3, 0, 0, 2, 15'd1);
        applyStimulus(32'hEC10, 0, 0, 0, 3, 15'd2);
        expectWrite(32'h5, 32'h6);
        applyStimulus(32'hE7C8, 0, 2, 0, 4, 15'd3);

        // Read-modify-write M=M+1 crossing the sign boundary.
        applyStimulus(32'h0005, 0, 0, 0, 2, 15'd4);
        expectRead(32'h5);
        expectWrite(32'h5, 32'h8000);
        applyStimulus(32'hFDC8, 0, 0, 32'h7FFF, 5, 15'd5);

        // D;JLT taken with D=-1, not taken with D=1.
        applyStimulus(32'h0010, 0, 0, 0, 2, 15'd6);
        applyStimulus(32'hEE90, 0, 0, 0, 3, 15'd7);
        applyStimulus(32'hE304, 0, 0, 0, 3, 15'h0010);
        applyStimulus(32'hEFD0, 0, 0, 0, 3, 15'h0011);
        applyStimulus(32'hE304, 0, 0, 0, 3, 15'h0012);

        // D=D+A and D=D&A observed through M=D writes.
        applyStimulus(32'h0003, 0, 0, 0, 2, 15'h0013);
        applyStimulus(32'hE090, 0, 0, 0, 3, 15'h0014);
        expectWrite(32'h3, 32'h4);
        applyStimulus(32'hE308, 0, 0, 0, 4, 15'h0015);
        applyStimulus(32'hE010, 0, 0, 0, 3, 15'h0016);
        expectWrite(32'h3, 32'h0);
        applyStimulus(32'hE308, 0, 1, 0, 4, 15'h0017);

        // Jump to the top of the program space, then let pc wrap to zero.
        applyStimulus(32'h7FFF, 0, 0, 0, 2, 15'h0018);
        applyStimulus(32'hEA87, 0, 0, 0, 3, 15'h7FFF);
        applyStimulus(32'h0001, 0, 0, 0, 2, 15'h0000);
        applyStimulus(32'hEA82, 0, 0, 0, 3, 15'h0001);
        applyStimulus(32'hEA81, 0, 0, 0, 3, 15'h0002);

        // Reset while a write is waiting in MWRITE.
        applyStimulus(32'h0009, 0, 0, 0, 2, 15'h0003);
        applyStimulus(32'hEC10, 0, 0, 0, 3, 15'h0004);
        instr_valid = 1'b1;
        instr_data  = 32'hE7C8;
        @(posedge clock);
        @(negedge clock);
        instr_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        checkOutput("abort_in_mwrite", {30'b0, o_mem_req, o_mem_we}, 32'h3);
        checkOutput("abort_wdata", o_mem_wdata, 32'hA);
        rst = 1'b0;
        #1;
        checkOutput("abort_mem_req_low", o_mem_req, 0);
        @(posedge clock);
        #1;
        checkOutput("abort_pc", o_pc, 0);
        checkOutput("abort_mem_req", o_mem_req, 0);
        checkOutput("abort_retired", o_retired, 0);
        @(negedge clock);
        rst = 1'b1;
        #1;
        checkOutput("abort_refetch", o_instr_req, 1);
        checkOutput("abort_refetch_addr", o_instr_addr, 0);
        model_pc = '0;
        expectWrite(32'h0, 32'h0);
        applyStimulus(32'hE308, 0, 0, 0, 4, 15'h0001);

        // 32-bit instance: -1 + 1 wraps to zero and takes JEQ.
        applyReset(1'b1);
        applyStimulus(32'hFFFF_EE90, 0, 0, 0, 3, 15'h0001);
        applyStimulus(32'h0000_0040, 0, 0, 0, 2, 15'h0002);
        expectWrite(32'h40, 32'h0);
        applyStimulus(32'hFFFF_E7CA, 0, 1, 0, 4, 15'h0040);
        applyStimulus(32'h7FFF_FFFF, 0, 0, 0, 2, 15'h0041);
        applyStimulus(32'hFFFF_EC10, 0, 0, 0, 3, 15'h0042);
        expectWrite(32'h7FFF_FFFF, 32'h7FFF_FFFF);
        applyStimulus(32'hFFFF_E308, 0, 0, 0, 4, 15'h0043);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
